// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked data-memory responder.
package dmem_pkg;

   localparam int WORD_BYTES = 4;
   localparam int ADDR_LSB   = 2;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef struct packed {
      logic                    write;
      logic [31:0]             addr;
      logic [31:0]             wdata;
      logic [WORD_BYTES-1:0]   be;
   } req_t;

   // Word index of a byte address lies inside a depth-word array.
   function automatic logic in_range(input logic [31:0] addr, input int depth);
      return (addr >> ADDR_LSB) < 32'(depth);
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between CPU data port and memory responder.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: byte-enable synchronous write, index-addressed read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         idx,
   input  logic [WORD_BYTES-1:0] be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   // Contents deliberately not reset; reset must never touch stored data.
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input logic   CLK,
   input logic   Reset,
   dmem_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   req_t          req_q;
   logic [31:0]   rdata_q;
   logic          err_q;
   logic          access, acc_err, we;
   logic [AW-1:0] idx;
   logic [31:0]   arr_rdata;

   assign idx     = req_q.addr[ADDR_LSB +: AW];
   assign access  = (state == WAIT) && (cnt == '0);
   assign acc_err = (req_q.addr[ADDR_LSB-1:0] != '0) || !in_range(req_q.addr, DEPTH);
   assign we      = access && req_q.write && !acc_err;

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk   (CLK),
      .we    (we),
      .idx   (idx),
      .be    (req_q.be),
      .wdata (req_q.wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.req_valid) state_nxt = WAIT;
         WAIT:    if (cnt == '0)     state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request is latched on acceptance so the initiator may drop it immediately.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cnt     <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (bus.req_valid) begin
               req_q <= '{write: bus.req_write, addr: bus.req_addr,
                          wdata: bus.req_wdata, be: bus.req_be};
               cnt   <= CW'(WAIT_CYCLES);
            end
            WAIT: if (cnt != '0) begin
               cnt <= cnt - CW'(1);
            end else begin
               err_q   <= acc_err;
               rdata_q <= (!acc_err && !req_q.write) ? arr_rdata : '0;
            end
            RESP: if (bus.rsp_ready) begin
               rdata_q <= '0;
               err_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Outputs come only from registers or the state register.
   assign bus.req_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder at WAIT_CYCLES=2 and 0.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int W0    = 2;
   localparam int W1    = 0;

   logic CLK   = 1'b0;
   logic Reset = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   dmem_if bus0();
   dmem_if bus1();

   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (.CLK(CLK), .Reset(Reset), .bus(bus0));
   dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (.CLK(CLK), .Reset(Reset), .bus(bus1));

   logic        sel, req_valid, req_write, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;

   assign bus0.req_valid = req_valid && !sel;
   assign bus1.req_valid = req_valid && sel;
   assign bus0.req_write = req_write;
   assign bus1.req_write = req_write;
   assign bus0.req_addr  = req_addr;
   assign bus1.req_addr  = req_addr;
   assign bus0.req_wdata = req_wdata;
   assign bus1.req_wdata = req_wdata;
   assign bus0.req_be    = req_be;
   assign bus1.req_be    = req_be;
   assign bus0.rsp_ready = rsp_ready;
   assign bus1.rsp_ready = rsp_ready;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   assign o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
   assign o_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
   assign o_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
   assign o_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [31:0] mem_m [2][DEPTH];
   logic [31:0] last_rd;
   int          rsp_cyc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: word-addressed byte memory with alignment and range rules.
   function automatic void model(input bit s, input bit wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 output logic [31:0] rd, output logic er);
      int w;
      er = (a % 4 != 0) || (a / 4 >= DEPTH);
      rd = '0;
      if (!er) begin
         w = int'(a / 4);
         if (wr) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) mem_m[s][w][8*i +: 8] = wd[8*i +: 8];
         end else begin
            rd = mem_m[s][w];
         end
      end
   endfunction

   task automatic send(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      int n = 0;
      req_write = wr; req_addr = a; req_wdata = wd; req_be = be; req_valid = 1'b1;
      @(negedge CLK);
      while (!o_req_ready && n < 50) begin @(negedge CLK); n++; end
      if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic recv(output logic [31:0] rd, output logic er, output int lat);
      lat = 0;
      do begin @(posedge CLK); #1; lat++; end while (!o_rsp_valid && lat < 50);
      if (!o_rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
      rd = o_rsp_rdata; er = o_rsp_err; rsp_cyc = cyc;
   endtask

   task automatic finish_hs();
      rsp_ready = 1'b1;
      @(posedge CLK); #1;
      chk("hs_valid", o_rsp_valid, 32'd0);
      chk("hs_rdata", o_rsp_rdata, 32'd0);
      chk("hs_err",   o_rsp_err,   32'd0);
   endtask

   task automatic xact(input bit s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
      logic [31:0] rd, erd;
      logic        er, eer;
      int          lat;
      sel = s;
      model(s, wr, a, wd, be, erd, eer);
      rsp_ready = (hold == 0);
      send(wr, a, wd, be);
      recv(rd, er, lat);
      chk("latency", lat, (s ? W1 : W0) + 1);
      chk("rdata", rd, erd);
      chk("err", er, eer);
      repeat (hold) begin
         @(posedge CLK); #1;
         chk("hold_valid", o_rsp_valid, 32'd1);
         chk("hold_rdata", o_rsp_rdata, rd);
      end
      last_rd = rd;
      finish_hs();
   endtask

   initial begin
      logic [31:0] rd, erd, hold_rd, a;
      logic        er, eer, hold_er;
      int          lat, prev, r;

      sel = 0; req_valid = 0; req_write = 0; rsp_ready = 1;
      req_addr = '0; req_wdata = '0; req_be = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_req_ready", o_req_ready, 32'd1);
      chk("rst_rsp_valid", o_rsp_valid, 32'd0);
      chk("rst_rdata",     o_rsp_rdata, 32'd0);
      chk("rst_err",       o_rsp_err,   32'd0);
      @(negedge CLK) Reset = 1'b1;

      // Define every word so later loads have known contents.
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < DEPTH; w++)
            xact(s[0], 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

      xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      xact(0, 0, 32'h10, 32'h0, 4'h0, 0);
      chk("t1_load", last_rd, 32'hDEADBEEF);

      xact(0, 1, 32'h20, 32'h11223344, 4'hF, 0);
      xact(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
      xact(0, 0, 32'h20, 32'h0, 4'h0, 0);
      chk("t2_merge", last_rd, 32'h11BB33DD);
      xact(0, 1, 32'h24, 32'hFFFFFFFF, 4'h0, 0);

      xact(0, 0, 32'h13, 32'h0, 4'h0, 0);
      xact(0, 1, 32'h100, 32'hCAFEF00D, 4'hF, 0);
      xact(0, 0, 32'h00, 32'h0, 4'h0, 0);

      // Response held off while a new request waits.
      sel = 0; rsp_ready = 0;
      model(0, 0, 32'h20, 32'h0, 4'h0, erd, eer);
      send(0, 32'h20, 32'h0, 4'h0);
      recv(hold_rd, hold_er, lat);
      chk("t4_rdata", hold_rd, 32'h11BB33DD);
      req_write = 0; req_addr = 32'h10; req_valid = 1;
      repeat (5) begin
         @(posedge CLK); #1;
         chk("t4_valid", o_rsp_valid, 32'd1);
         chk("t4_rdata_stable", o_rsp_rdata, hold_rd);
         chk("t4_err_stable", o_rsp_err, hold_er);
         chk("t4_req_ready", o_req_ready, 32'd0);
      end
      rsp_ready = 1;
      @(posedge CLK); #1;
      chk("t4_hs_valid", o_rsp_valid, 32'd0);
      chk("t4_idle_ready", o_req_ready, 32'd1);
      @(posedge CLK); #1;
      chk("t4_accepted", o_req_ready, 32'd0);
      req_valid = 0;
      model(0, 0, 32'h10, 32'h0, 4'h0, erd, eer);
      recv(rd, er, lat);
      chk("t4_lat2", lat, W0 + 1);
      chk("t4_rdata2", rd, erd);
      finish_hs();

      // Reset while a store sits in its wait states.
      xact(0, 1, 32'h30, 32'h99, 4'hF, 0);
      sel = 0; rsp_ready = 1;
      send(1, 32'h30, 32'h55, 4'hF);
      @(posedge CLK); #1;
      Reset = 1'b0;
      #1;
      chk("t5_req_ready", o_req_ready, 32'd1);
      chk("t5_rsp_valid", o_rsp_valid, 32'd0);
      chk("t5_rdata",     o_rsp_rdata, 32'd0);
      chk("t5_err",       o_rsp_err,   32'd0);
      @(negedge CLK) Reset = 1'b1;
      xact(0, 0, 32'h30, 32'h0, 4'h0, 0);
      chk("t5_kept", last_rd, 32'h99);

      // Zero-wait back-to-back loads.
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         xact(1, 0, 32'(k * 8), 32'h0, 4'h0, 0);
         if (prev >= 0) chk("b2b_gap", 32'(rsp_cyc - prev), 32'd3);
         prev = rsp_cyc;
      end

      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         else if (r == 1) a = 32'($urandom_range(DEPTH, 'h3FFF) * 4);
         else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
         xact(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
